icache: RTL and testbench
=========================

# icache

Direct-mapped instruction cache between the instruction-fetch stage and the memory controller. Serves word fetches from a local tag/data array in one cycle on a hit. On a miss it issues a single 4-byte read through the memory controller's icache request port and fills the line. Supports a flush (`clear`) from the ROB on misprediction without corrupting controller handshakes.

## Interface
- `INDEX_BITS`, 4, log2 of line count (one 32-bit word per line); tag = `pc[31:INDEX_BITS+2]`, index = `pc[INDEX_BITS+1:2]`, `pc[1:0]` ignored.
- `clk_in`  in  1  clock; everything is on posedge.
- `rst_in`  in  1  synchronous, active-high reset.
- `rdy_in`  in  1  global ready; low freezes all state and outputs.
- `clear`  in  1  flush pending fetch (branch mispredict).
- `fetch_valid`  in  1  fetch request; held by the fetcher until `inst_ready`.
- `fetch_pc`  in  32  fetch address.
- `inst_ready`  out  1  one-cycle pulse: `inst`/`inst_pc` valid.
- `inst`  out  32  instruction word.
- `inst_pc`  out  32  pc the instruction belongs to.
- `mem_req`  out  1  request to memory controller (its `icache_in`).
- `mem_addr`  out  32  word-aligned fill address.
- `mem_received`  in  1  controller accepted the request.
- `mem_done`  in  1  one-cycle pulse: fill data valid.
- `mem_data`  in  32  fill data (controller `value_load`).

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: accept when `fetch_valid && !inst_ready && !clear`. Latch pc.
  - Hit (valid[idx] && tag match): next cycle `inst_ready`=1, `inst`=data[idx], `inst_pc`=pc; stay IDLE.
  - Miss: go REQ; `mem_req`=1, `mem_addr`={pc[31:2],2'b00}.
- REQ: hold `mem_req`/`mem_addr` until `mem_received`=1. Then drop `mem_req` the following cycle and go WAIT.
- WAIT: on `mem_done`, write data[idx], tag[idx], and set valid[idx]. Unless discarding, pulse `inst_ready` next cycle with `mem_data`; go IDLE.
- `clear` in IDLE: no accept that cycle; suppress any `inst_ready` scheduled for next cycle.
- `clear` in REQ before `mem_received`: drop `mem_req`, go IDLE.
- `clear` in REQ on the `mem_received` cycle, or in WAIT: set `discard`. Stay in the flow until `mem_done`, still fill the line, and never pulse `inst_ready`. The controller cannot abort.
- `clear` never invalidates array contents; instructions are immutable.
- Reset: all valid bits 0, state IDLE, `discard`=0. Outputs `inst_ready`, `inst`, `inst_pc`, `mem_req`, `mem_addr` all 0.
- Reset mid-fill: return to IDLE immediately. A stale `mem_done` arriving in IDLE is ignored.

## Timing
- Hit latency: `inst_ready` 1 cycle after acceptance edge.
- Miss latency: `inst_ready` 1 cycle after `mem_done`. There is at least 1 cycle from `mem_req` to `mem_received`, plus controller load time.
- `mem_req` is never high in the cycle after `mem_received`. This prevents double issue.
- Back-to-back hits: a new fetch can be accepted every 2 cycles. The cycle with `inst_ready`=1 blocks acceptance, so the fetcher's stale pc is not re-served.
- `rdy_in`=0: no state, array, or output change. Pulses are held until `rdy_in` returns.

## Configuration
- `ICACHE_EN` defined: the behaviour above.
- `ICACHE_EN` undefined: no arrays are instantiated, and every fetch is treated as a miss (IDLE→REQ→WAIT). Fill writes are dropped. Handshakes and `clear` behave identically. Used for debug and area comparison.

## Structure
- Shared package/header holds:
  - state encodings `ICACHE_IDLE`/`ICACHE_REQ`/`ICACHE_WAIT`;
  - `INST_WIDTH`=32;
  - the word-fetch width constant 4, which matches the controller's width encoding.
- One sub-module, `icache_array`, holds:
  - inputs `INDEX_BITS`, `rd_idx`, `wr_en`, `wr_idx`, `wr_tag`, `wr_data`;
  - outputs `rd_valid`, `rd_tag`, `rd_data`.
- `icache_array` has registered storage and a combinational read. Valid bits are cleared on `rst_in`.

## Test plan
- Cold miss: reset, `fetch_pc`=0x0000_1000. Requirements:
  - one `mem_req` with `mem_addr`=0x1000;
  - after `mem_received`, model `mem_done` with 0x0000_0513;
  - `inst_ready` pulses once with `inst`=0x0000_0513 and `inst_pc`=0x1000.
- Hit after fill: refetch 0x1000 → `inst_ready` 1 cycle later, same data, `mem_req` stays 0.
- Conflict: with INDEX_BITS=4, fetch 0x1000 then 0x1040 (same index, different tag). Requirements:
  - the second fetch misses and refills;
  - a third fetch of 0x1000 misses again.
- Clear in WAIT: `clear` pulsed between `mem_received` and `mem_done` (data 0xDEAD_BEEF). Requirements:
  - no `inst_ready`;
  - a subsequent fetch of the same pc hits with 0xDEAD_BEEF.
- Clear in REQ: controller model delays `mem_received`; `clear` asserted → `mem_req` falls next cycle, state IDLE, no fill.
- Stall: hold `rdy_in`=0 for 3 cycles during REQ → `mem_req`/`mem_addr` unchanged; completes normally after release.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared constants and types for the direct-mapped instruction cache.
package icache_pkg;

  localparam int INST_WIDTH = 32;

  // Word-fetch width code; matches the memory controller's 4-byte load encoding.
  localparam logic [2:0] FETCH_WIDTH = 3'd4;

  typedef enum logic [1:0] {
    ICACHE_IDLE = 2'd0,
    ICACHE_REQ  = 2'd1,
    ICACHE_WAIT = 2'd2
  } icache_state_t;

  // Word-aligned address of the instruction containing pc.
  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side and memory-controller-side signals of the instruction cache.
// The slave modport is the cache's view; master is the fetcher/controller view.
interface icache_if;
  import icache_pkg::*;

  logic                  fetch_valid;
  logic [31:0]           fetch_pc;
  logic                  inst_ready;
  logic [INST_WIDTH-1:0] inst;
  logic [31:0]           inst_pc;
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic                  mem_received;
  logic                  mem_done;
  logic [INST_WIDTH-1:0] mem_data;

  modport slave (
    input  fetch_valid, fetch_pc, mem_received, mem_done, mem_data,
    output inst_ready, inst, inst_pc, mem_req, mem_addr
  );

  modport master (
    output fetch_valid, fetch_pc, mem_received, mem_done, mem_data,
    input  inst_ready, inst, inst_pc, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_array.sv
// icache_array: tag/data/valid storage, one 32-bit word per line.
// Registered writes, combinational read; valid bits clear on reset.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [INDEX_BITS-1:0]   rd_idx,
  input  logic                    wr_en,
  input  logic [INDEX_BITS-1:0]   wr_idx,
  input  logic [29-INDEX_BITS:0]  wr_tag,
  input  logic [INST_WIDTH-1:0]   wr_data,
  output logic                    rd_valid,
  output logic [29-INDEX_BITS:0]  rd_tag,
  output logic [INST_WIDTH-1:0]   rd_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid_q;
  logic [29-INDEX_BITS:0] tag_q  [LINES];
  logic [INST_WIDTH-1:0]  data_q [LINES];

  // Valid bits: cleared by reset, set when a line is filled.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data payload; never reset, only meaningful behind a valid bit.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache between fetch and the memory controller.
// Define ICACHE_EN to build the tag/data array; without it every fetch is
// served through the controller and fills are dropped.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  logic    rdy_in,
  input  logic    clear,
  icache_if.slave bus
);

  icache_state_t         state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic                  discard_q, discard_d;
  logic                  inst_ready_q, inst_ready_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [31:0]           inst_pc_q, inst_pc_d;
  logic                  mem_req_q, mem_req_d;
  logic [31:0]           mem_addr_q, mem_addr_d;

  logic                  accept;
  logic                  hit;
  logic [INST_WIDTH-1:0] hit_data;

  // The cycle carrying inst_ready blocks acceptance so a stale pc is not re-served.
  assign accept = bus.fetch_valid && !inst_ready_q && !clear;

`ifdef ICACHE_EN
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [INST_WIDTH-1:0] rd_data;
  logic                  wr_en;

  // Fill happens even when the fetch was discarded: instructions are immutable.
  assign wr_en = rdy_in && !rst_in && (state_q == ICACHE_WAIT) && bus.mem_done;

  icache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rd_idx   (bus.fetch_pc[INDEX_BITS+1:2]),
    .wr_en    (wr_en),
    .wr_idx   (pc_q[INDEX_BITS+1:2]),
    .wr_tag   (pc_q[31:INDEX_BITS+2]),
    .wr_data  (bus.mem_data),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  assign hit      = rd_valid && (rd_tag == bus.fetch_pc[31:INDEX_BITS+2]);
  assign hit_data = rd_data;
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // State and registered outputs; rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ICACHE_IDLE;
      pc_q         <= '0;
      discard_q    <= 1'b0;
      inst_ready_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      inst_ready_q <= inst_ready_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Next-state: misses walk REQ -> WAIT; clear before acceptance by the controller aborts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ICACHE_IDLE: if (accept && !hit) state_d = ICACHE_REQ;
      ICACHE_REQ: begin
        if (bus.mem_received) state_d = ICACHE_WAIT;
        else if (clear)       state_d = ICACHE_IDLE;
      end
      ICACHE_WAIT: if (bus.mem_done) state_d = ICACHE_IDLE;
      default:     state_d = ICACHE_IDLE;
    endcase
  end

  // Output/datapath next values: hit reply, request issue, discard tracking, fill reply.
  always_comb begin
    pc_d         = pc_q;
    discard_d    = discard_q;
    inst_ready_d = 1'b0;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    case (state_q)
      ICACHE_IDLE: begin
        if (accept) begin
          pc_d = bus.fetch_pc;
          if (hit) begin
            inst_ready_d = 1'b1;
            inst_d       = hit_data;
            inst_pc_d    = bus.fetch_pc;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = word_addr(bus.fetch_pc);
          end
        end
      end
      ICACHE_REQ: begin
        if (bus.mem_received) begin
          mem_req_d = 1'b0;
          discard_d = discard_q || clear;
        end else if (clear) begin
          mem_req_d = 1'b0;
        end
      end
      ICACHE_WAIT: begin
        discard_d = discard_q || clear;
        if (bus.mem_done) begin
          discard_d = 1'b0;
          if (!(discard_q || clear)) begin
            inst_ready_d = 1'b1;
            inst_d       = bus.mem_data;
            inst_pc_d    = pc_q;
          end
        end
      end
      default: begin
        mem_req_d = 1'b0;
        discard_d = 1'b0;
      end
    endcase
  end

  assign bus.inst_ready = inst_ready_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb_icache: table-driven fetch vectors plus hand-written clear/stall/reset sequences.
// Expected instructions go into a scoreboard queue when a fetch is driven and are
// compared when inst_ready pulses. Follows the ICACHE_EN setting of the build.
module tb_icache;
  import icache_pkg::*;

  localparam int IDX = 4;
`ifdef ICACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear;

  icache_if bus();

  icache #(.INDEX_BITS(IDX)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          hit;
    int          stall;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic scoreInst();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_inst: got inst_pc 0x%08h expected no output", bus.inst_pc);
    end else begin
      e = exp_q.pop_front();
      checkOutput("inst", bus.inst, e.inst);
      checkOutput("inst_pc", bus.inst_pc, e.pc);
    end
  endtask

  // One fetch, with a controller model answering any miss; data doubles as fill and expected word.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] data,
                               input bit exp_hit, input int stall);
    bit eff_hit;
    int cyc, reqs, extra, done_cyc, ready_cyc, load, phase;
    eff_hit   = exp_hit && CACHE_ON;
    exp_q.push_back('{pc: pc, inst: data});
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = pc;
    cyc = 0; reqs = 0; extra = 0; done_cyc = -1; ready_cyc = -1; load = 0; phase = 0;
    while (ready_cyc < 0 && cyc < 60) begin
      tick();
      cyc++;
      bus.mem_received = 1'b0;
      bus.mem_done     = 1'b0;
      if (bus.inst_ready) begin
        ready_cyc = cyc;
        scoreInst();
      end else begin
        case (phase)
          0: if (bus.mem_req) begin
               reqs++;
               checkOutput("mem_addr", bus.mem_addr, {pc[31:2], 2'b00});
               if (stall > 0) begin
                 rdy_in = 1'b0;
                 for (int s = 0; s < stall; s++) begin
                   tick();
                   checkOutput("stall_mem_req", 32'(bus.mem_req), 32'd1);
                   checkOutput("stall_mem_addr", bus.mem_addr, {pc[31:2], 2'b00});
                 end
                 rdy_in = 1'b1;
               end
               bus.mem_received = 1'b1;
               phase = 1;
             end
          1: begin
               if (bus.mem_req) extra++;
               load  = 2;
               phase = 2;
             end
          2: begin
               if (bus.mem_req) extra++;
               if (load == 0) begin
                 bus.mem_done = 1'b1;
                 bus.mem_data = data;
                 done_cyc     = cyc;
                 phase        = 3;
               end else begin
                 load--;
               end
             end
          default: if (bus.mem_req) extra++;
        endcase
      end
    end
    if (ready_cyc < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL fetch_timeout: pc 0x%08h got no inst_ready expected one", pc);
      void'(exp_q.pop_back());
    end else begin
      if (eff_hit) checkOutput("hit_latency", ready_cyc, 32'd1);
      else         checkOutput("miss_latency", ready_cyc, done_cyc + 1);
      checkOutput("mem_req_count", reqs, eff_hit ? 32'd0 : 32'd1);
      checkOutput("double_issue", extra, 32'd0);
      // fetch_valid is still high across the inst_ready cycle: it must not be re-accepted
      tick();
      checkOutput("ready_pulse_width", 32'(bus.inst_ready), 32'd0);
      checkOutput("stale_accept", 32'(bus.mem_req), 32'd0);
    end
    bus.fetch_valid  = 1'b0;
    bus.mem_received = 1'b0;
    bus.mem_done     = 1'b0;
  endtask

  // Mispredict after the controller accepted: fill completes silently.
  task automatic clearInWait();
    int phase, load, post, readies, cyc;
    phase = 0; load = 0; post = 0; readies = 0; cyc = 0;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h0000_2000;
    while (post < 4 && cyc < 40) begin
      tick();
      cyc++;
      bus.mem_received = 1'b0;
      bus.mem_done     = 1'b0;
      clear            = 1'b0;
      if (bus.inst_ready) readies++;
      case (phase)
        0: if (bus.mem_req) begin bus.mem_received = 1'b1; phase = 1; end
        1: begin clear = 1'b1; bus.fetch_valid = 1'b0; load = 2; phase = 2; end
        2: if (load == 0) begin
             bus.mem_done = 1'b1;
             bus.mem_data = 32'hDEAD_BEEF;
             phase = 3;
           end else begin
             load--;
           end
        default: post++;
      endcase
    end
    checkOutput("clear_wait_flow", phase, 32'd3);
    checkOutput("clear_wait_no_ready", readies, 32'd0);
    applyStimulus(32'h0000_2000, 32'hDEAD_BEEF, 1'b1, 0);
  endtask

  // Mispredict while the controller stalls on the request: request withdrawn, no fill.
  task automatic clearInReq();
    int cyc, readies, reqs;
    cyc = 0; readies = 0; reqs = 0;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h0000_3000;
    while (!bus.mem_req && cyc < 10) begin
      tick();
      cyc++;
    end
    checkOutput("clear_req_issued", 32'(bus.mem_req), 32'd1);
    tick();
    checkOutput("clear_req_held", 32'(bus.mem_req), 32'd1);
    clear           = 1'b1;
    bus.fetch_valid = 1'b0;
    tick();
    clear = 1'b0;
    checkOutput("clear_req_drop", 32'(bus.mem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.inst_ready) readies++;
      if (bus.mem_req) reqs++;
    end
    checkOutput("clear_req_no_ready", readies, 32'd0);
    checkOutput("clear_req_no_reissue", reqs, 32'd0);
    applyStimulus(32'h0000_3000, 32'h3333_0001, 1'b0, 0);
  endtask

  // Reset during a fill, then a stale mem_done: ignored, and the array is empty again.
  task automatic resetMidFill();
    int cyc, readies;
    cyc = 0; readies = 0;
    bus.fetch_valid = 1'b1;
    bus.fetch_pc    = 32'h0000_5000;
    while (!bus.mem_req && cyc < 10) begin
      tick();
      cyc++;
    end
    bus.mem_received = 1'b1;
    tick();
    bus.mem_received = 1'b0;
    rst_in           = 1'b1;
    bus.fetch_valid  = 1'b0;
    tick();
    rst_in = 1'b0;
    checkOutput("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("rst_mid_inst", bus.inst, 32'd0);
    checkOutput("rst_mid_inst_pc", bus.inst_pc, 32'd0);
    checkOutput("rst_mid_mem_addr", bus.mem_addr, 32'd0);
    bus.mem_done = 1'b1;
    bus.mem_data = 32'h5555_0000;
    tick();
    bus.mem_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.inst_ready) readies++;
      tick();
    end
    checkOutput("stale_done_ignored", readies, 32'd0);
    applyStimulus(32'h0000_1000, 32'h0000_0513, 1'b0, 0);
    applyStimulus(32'h0000_5000, 32'h5555_0001, 1'b0, 0);
  endtask

  initial begin
    rst_in           = 1'b1;
    rdy_in           = 1'b1;
    clear            = 1'b0;
    bus.fetch_valid  = 1'b0;
    bus.fetch_pc     = '0;
    bus.mem_received = 1'b0;
    bus.mem_done     = 1'b0;
    bus.mem_data     = '0;

    vecs[0]  = '{pc: 32'h0000_1000, data: 32'h0000_0513, hit: 1'b0, stall: 0};
    vecs[1]  = '{pc: 32'h0000_1000, data: 32'h0000_0513, hit: 1'b1, stall: 0};
    vecs[2]  = '{pc: 32'h0000_1040, data: 32'h00A0_0093, hit: 1'b0, stall: 0};
    vecs[3]  = '{pc: 32'h0000_1000, data: 32'h0000_0513, hit: 1'b0, stall: 0};
    vecs[4]  = '{pc: 32'h0000_1007, data: 32'h0010_0113, hit: 1'b0, stall: 0};
    vecs[5]  = '{pc: 32'h0000_1006, data: 32'h0010_0113, hit: 1'b1, stall: 0};
    vecs[6]  = '{pc: 32'h0000_1000, data: 32'h0000_0513, hit: 1'b1, stall: 0};
    vecs[7]  = '{pc: 32'hFFFF_FFFC, data: 32'h1234_5678, hit: 1'b0, stall: 0};
    vecs[8]  = '{pc: 32'hFFFF_FFFC, data: 32'h1234_5678, hit: 1'b1, stall: 0};
    vecs[9]  = '{pc: 32'h0000_003C, data: 32'h0BAD_F00D, hit: 1'b0, stall: 0};
    vecs[10] = '{pc: 32'hFFFF_FFFC, data: 32'h1234_5678, hit: 1'b0, stall: 0};
    vecs[11] = '{pc: 32'h0000_4000, data: 32'h4444_0001, hit: 1'b0, stall: 3};

    tick();
    tick();
    rst_in = 1'b0;
    checkOutput("reset_inst_ready", 32'(bus.inst_ready), 32'd0);
    checkOutput("reset_inst", bus.inst, 32'd0);
    checkOutput("reset_inst_pc", bus.inst_pc, 32'd0);
    checkOutput("reset_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("reset_mem_addr", bus.mem_addr, 32'd0);

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].pc, vecs[v].data, vecs[v].hit, vecs[v].stall);
    end

    clearInWait();
    clearInReq();
    resetMidFill();

    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
